// File: rtl/serial_chunk_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_chunk_addsub
// Brief    : Multi-cycle SIZE-bit adder/subtractor, CHUNK bits per cycle,
//            with ready/valid handshakes on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_chunk_addsub #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] s,
  output logic            carryout,
  output logic            overflow
);

  localparam int c_n  = SIZE / CHUNK;
  localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_kw-1:0] c_last = c_kw'(c_n - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic            r_carry;
  logic [c_kw-1:0] r_k;
  logic [SIZE-1:0] r_acc;

  logic [CHUNK:0]  w_sum;
  logic            w_msb_cin;
  logic [SIZE-1:0] w_ins;
  logic [SIZE-1:0] w_acc_next;
  logic            w_accept;
  logic            w_last;

  // Operands are consumed from the bottom: the low CHUNK bits of r_a/r_b are
  // always the chunk being added, and the registers shift right each cycle.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_carry};

  // Carry into the chunk's top bit, recovered from its sum bit; on the last
  // chunk this is the carry into bit SIZE-1.
  assign w_msb_cin = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];

  // Result bits enter the accumulator at the top and drift down, so after
  // N shifts chunk 0 sits at the bottom. With N=1 the shift clears r_acc.
  assign w_ins      = SIZE'(w_sum[CHUNK-1:0]) << (SIZE - CHUNK);
  assign w_acc_next = (r_acc >> CHUNK) | w_ins;

  assign w_accept = (r_state == c_idle) && in_valid;
  assign w_last   = (r_k == c_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_state_next = c_busy;
      c_busy:  if (w_last)    w_state_next = c_done;
      c_done:  if (out_ready) w_state_next = c_idle;
      default:                w_state_next = c_idle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
  end

  // Datapath: capture operands on accept, add one chunk per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_acc    <= '0;
      s        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub | cin;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (r_state == c_busy) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_sum[CHUNK];
      r_k     <= r_k + c_kw'(1);
      r_acc   <= w_acc_next;
      if (w_last) begin
        s        <= w_acc_next;
        carryout <= w_sum[CHUNK];
        overflow <= w_sum[CHUNK] ^ w_msb_cin;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_chunk_addsub
// Brief    : Directed and randomised self-checking bench for
//            serial_chunk_addsub (32/8, 32/32 and 16/4 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // 32/8 instance
  logic        in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 0;
  logic        carryout, overflow;
  logic [31:0] a = '0, b = '0, s;

  serial_chunk_addsub #(.SIZE(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .carryout(carryout), .overflow(overflow)
  );

  // 32/32 instance (N=1)
  logic        in_valid1 = 0, in_ready1, cin1 = 0, sub1 = 0, out_valid1, out_ready1 = 0;
  logic        carryout1, overflow1;
  logic [31:0] a1 = '0, b1 = '0, s1;

  serial_chunk_addsub #(.SIZE(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .s(s1), .carryout(carryout1), .overflow(overflow1)
  );

  // 16/4 instance
  logic        in_valid2 = 0, in_ready2, cin2 = 0, sub2 = 0, out_valid2, out_ready2 = 0;
  logic        carryout2, overflow2;
  logic [15:0] a2 = '0, b2 = '0, s2;

  serial_chunk_addsub #(.SIZE(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .s(s2), .carryout(carryout2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 32/8 instance with hand-computed expectations
  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                     input logic tc, input logic ts,
                     input logic [31:0] es, input logic ec, input logic eo);
    int cnt;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1;
    tick();
    in_valid = 0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, ".latency"}, 64'(cnt), 64'd4);
    chk({tag, ".s"}, 64'(s), 64'(es));
    chk({tag, ".carryout"}, 64'(carryout), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  // Random operation on the 32/32 instance
  task automatic rnd1();
    logic [31:0] ra, rb, bb;
    logic        rc, rs, eo;
    logic [32:0] full;
    int          cnt;
    ra = $urandom; rb = $urandom;
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + 33'(rs ? 1'b1 : rc);
    eo   = (ra[31] == bb[31]) && (full[31] != ra[31]);
    a1 = ra; b1 = rb; cin1 = rc; sub1 = rs; in_valid1 = 1;
    tick();
    in_valid1 = 0;
    cnt = 0;
    while (!out_valid1 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("w32.latency", 64'(cnt), 64'd1);
    chk("w32.s", 64'(s1), 64'(full[31:0]));
    chk("w32.carryout", 64'(carryout1), 64'(full[32]));
    chk("w32.overflow", 64'(overflow1), 64'(eo));
    out_ready1 = 1;
    tick();
    out_ready1 = 0;
  endtask

  // Random operation on the 16/4 instance
  task automatic rnd2();
    logic [15:0] ra, rb, bb;
    logic        rc, rs, eo;
    logic [16:0] full;
    int          cnt;
    ra = 16'($urandom); rb = 16'($urandom);
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + 17'(rs ? 1'b1 : rc);
    eo   = (ra[15] == bb[15]) && (full[15] != ra[15]);
    a2 = ra; b2 = rb; cin2 = rc; sub2 = rs; in_valid2 = 1;
    tick();
    in_valid2 = 0;
    cnt = 0;
    while (!out_valid2 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("n16.latency", 64'(cnt), 64'd4);
    chk("n16.s", 64'(s2), 64'(full[15:0]));
    chk("n16.carryout", 64'(carryout2), 64'(full[16]));
    chk("n16.overflow", 64'(overflow2), 64'(eo));
    out_ready2 = 1;
    tick();
    out_ready2 = 0;
  endtask

  initial begin
    // Reset state, before any clock edge sees rst_n high
    #12;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.s", 64'(s), 64'd0);
    chk("rst.carryout", 64'(carryout), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Directed arithmetic
    run("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run("add_neg",  32'hFFFF_FFE1, 32'hFFFF_FFE1, 1'b1, 1'b0, 32'hFFFF_FFC3, 1'b1, 1'b0);
    run("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure, with operands disturbed while BUSY
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 0; sub = 0; in_valid = 1;
    tick();
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1; sub = 1;
    repeat (4) tick();
    in_valid = 0;
    chk("bp.out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("bp.s", 64'(s), 64'h2345_6789);
      chk("bp.carryout", 64'(carryout), 64'd0);
      chk("bp.overflow", 64'(overflow), 64'd0);
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp.release_ready", 64'(in_ready), 64'd1);
    chk("bp.release_valid", 64'(out_valid), 64'd0);
    chk("bp.s_kept", 64'(s), 64'h2345_6789);

    // Reset after the second BUSY edge
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 0; sub = 0; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst.s", 64'(s), 64'd0);
    @(negedge clk);
    rst_n = 1;
    run("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Parameter sweep
    for (int i = 0; i < 1000; i++) rnd1();
    for (int i = 0; i < 1000; i++) rnd2();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
